// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-register-file bundle: write-back sources and control in,
// decode read ports, forwarding info and the retired-write counter out.
interface writeback_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pcInc;
    logic [XLEN-1:0]  ALURes;
    logic [XLEN-1:0]  DMDataRd;
    logic [4:0]       rd;
    logic             RUWr;
    logic [1:0]       RUDataWrSrc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  ru_rs1;
    logic [XLEN-1:0]  ru_rs2;
    logic [XLEN-1:0]  wb_data;
    logic [4:0]       wb_rd;
    logic             wb_valid;
    logic [CNT_W-1:0] retired_writes;

    modport master (
        output pcInc, ALURes, DMDataRd, rd, RUWr, RUDataWrSrc, rs1, rs2,
        input  ru_rs1, ru_rs2, wb_data, wb_rd, wb_valid, retired_writes
    );

    modport slave (
        input  pcInc, ALURes, DMDataRd, rd, RUWr, RUDataWrSrc, rs1, rs2,
        output ru_rs1, ru_rs2, wb_data, wb_rd, wb_valid, retired_writes
    );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back stage: selects the write-back value, commits it to the 32 x XLEN
// register file, and serves two bypassed combinational read ports.
module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    writeback_regfile_if.slave  wb
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [XLEN-1:0]  wb_data;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             we_eff;

    // Reserved source 2'b11 yields zero and also blocks the write below.
    always_comb begin
        case (wb.RUDataWrSrc)
            2'b00:   wb_data = wb.ALURes;
            2'b01:   wb_data = wb.DMDataRd;
            2'b10:   wb_data = wb.pcInc;
            default: wb_data = '0;
        endcase
    end

    assign we_eff = wb.RUWr && (wb.rd != 5'd0) && (wb.RUDataWrSrc != 2'b11) && !rst;

    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path leaves a value held and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (we_eff) begin
            regs_d[wb.rd] = wb_data;
            cnt_d         = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    // NOTE: the array is reset because x1..x31 must read zero after reset;
    // this rules out mapping it onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    // x0 reads zero; a matching in-flight write is forwarded to decode.
    always_comb begin
        rs1_data = regs_q[wb.rs1];
        if (wb.rs1 == 5'd0)
            rs1_data = '0;
        else if (we_eff && (wb.rs1 == wb.rd))
            rs1_data = wb_data;

        rs2_data = regs_q[wb.rs2];
        if (wb.rs2 == 5'd0)
            rs2_data = '0;
        else if (we_eff && (wb.rs2 == wb.rd))
            rs2_data = wb_data;
    end

    assign wb.ru_rs1         = rs1_data;
    assign wb.ru_rs2         = rs2_data;
    assign wb.wb_data        = wb_data;
    assign wb.wb_valid       = we_eff;
    assign wb.wb_rd          = we_eff ? wb.rd : 5'd0;
    assign wb.retired_writes = cnt_q;
endmodule
